// File: rtl/swm_pkg.sv
// ----------------------------------------------------------------------------
// swm_pkg
//   Shared definitions for the SWM RX packet buffer:
//     - SWM_ENTRY_W : width of one buffer entry {sop, eop, data[31:0]}
//     - wr_state_e  : write-side FSM states
// ----------------------------------------------------------------------------
package swm_pkg;

    localparam int unsigned SWM_ENTRY_W = 34;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_RECV    = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_e;

endpackage

// File: rtl/swm_sdp_ram.sv
// ----------------------------------------------------------------------------
// swm_sdp_ram
//   Simple dual-port RAM, one clock, registered read data.
//   Ports:
//     clk_i      : clock
//     wr_en_i    : write enable
//     wr_addr_i  : write address
//     wr_data_i  : write data
//     rd_en_i    : read enable (rd_data_o updates on the next edge)
//     rd_addr_i  : read address
//     rd_data_o  : registered read data
// ----------------------------------------------------------------------------
module swm_sdp_ram #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 512,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/swm_rx_pkt_buffer.sv
// ----------------------------------------------------------------------------
// swm_rx_pkt_buffer
//   Store-and-forward Avalon-ST packet buffer. A packet becomes visible on the
//   source only after its EOP word has been written; incomplete, interrupted
//   or oversized packets are discarded and flagged on pkt_dropped.
//
//   Ports:
//     clk_in_clk              : clock
//     reset_in_rst_n          : asynchronous active-low reset
//     avalonst_sink_*         : input packet stream (data/valid/sop/eop)
//     avalonst_sink_ready     : always 1 outside reset (no backpressure)
//     avalonst_source_*       : buffered packet stream (data/valid/sop/eop)
//     avalonst_source_ready   : downstream ready
//     pkt_dropped             : one-cycle pulse per discarded packet
//
//   Optional (macro SWM_RX_PKT_BUFFER_STATS_EN):
//     drop_count[15:0]        : saturating count of pkt_dropped pulses
//     pkt_count[15:0]         : wrapping count of committed packets
// ----------------------------------------------------------------------------
module swm_rx_pkt_buffer
    import swm_pkg::*;
#(
    parameter int unsigned DEPTH = 512
) (
    input  logic        clk_in_clk,
    input  logic        reset_in_rst_n,
    input  logic [31:0] avalonst_sink_data,
    input  logic        avalonst_sink_valid,
    input  logic        avalonst_sink_startofpacket,
    input  logic        avalonst_sink_endofpacket,
    output logic        avalonst_sink_ready,
    output logic [31:0] avalonst_source_data,
    output logic        avalonst_source_valid,
    output logic        avalonst_source_startofpacket,
    output logic        avalonst_source_endofpacket,
    input  logic        avalonst_source_ready,
`ifdef SWM_RX_PKT_BUFFER_STATS_EN
    output logic [15:0] drop_count,
    output logic [15:0] pkt_count,
`endif
    output logic        pkt_dropped
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Write side
    wr_state_e           state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       wr_commit_q, wr_commit_d;
    logic [PW-1:0]       wr_base;
    logic                orphan_q, orphan_d;
    logic                drop_q, drop_d;
    logic                ready_q;
    logic                beat, wants_write, restart, full, commit;
    logic                ram_we;
    logic [AW-1:0]       ram_waddr;

    // Read side
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic                   rd_en, pop;
    logic [1:0]             occ;
    logic                   ram_vld_q;
    logic [SWM_ENTRY_W-1:0] ram_rdata;
    logic [SWM_ENTRY_W-1:0] out_q, out_d, skid_q, skid_d;
    logic                   out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;

    assign beat = avalonst_sink_valid && ready_q;
    // Full check uses the read pointer from before this cycle's read.
    assign full = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        orphan_d    = orphan_q;
        drop_d      = 1'b0;
        ram_we      = 1'b0;
        restart     = 1'b0;
        commit      = 1'b0;
        wr_base     = wr_ptr_q;

        case (state_q)
            WR_RECV: wants_write = 1'b1;
            default: wants_write = avalonst_sink_startofpacket;
        endcase

        if (beat) begin
            if (wants_write && full) begin
                wr_ptr_d = wr_commit_q;
                drop_d   = 1'b1;
                orphan_d = 1'b0;
                state_d  = avalonst_sink_endofpacket ? WR_IDLE : WR_DISCARD;
            end else if (wants_write) begin
                // A SOP inside RECV abandons the partial packet and restarts
                // the write at the last commit point.
                restart  = (state_q == WR_RECV) && avalonst_sink_startofpacket;
                wr_base  = restart ? wr_commit_q : wr_ptr_q;
                ram_we   = 1'b1;
                wr_ptr_d = wr_base + PW'(1);
                drop_d   = restart;
                orphan_d = 1'b0;
                if (avalonst_sink_endofpacket) begin
                    wr_commit_d = wr_base + PW'(1);
                    commit      = 1'b1;
                    state_d     = WR_IDLE;
                end else begin
                    state_d     = WR_RECV;
                end
            end else if (state_q == WR_IDLE) begin
                // Orphan words: one pulse per run, a run ends at EOP.
                drop_d   = !orphan_q;
                orphan_d = !avalonst_sink_endofpacket;
            end else if (avalonst_sink_endofpacket) begin
                state_d = WR_IDLE;
            end
        end
    end

    assign ram_waddr = wr_base[AW-1:0];

    swm_sdp_ram #(
        .WIDTH (SWM_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i     (clk_in_clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (ram_waddr),
        .wr_data_i ({avalonst_sink_startofpacket, avalonst_sink_endofpacket, avalonst_sink_data}),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (ram_rdata)
    );

    // Reads are issued only when the out/skid pair can absorb every word
    // already in flight from the RAM plus the one being requested.
    assign pop   = out_vld_q && avalonst_source_ready;
    assign occ   = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, ram_vld_q};
    assign rd_en = (rd_ptr_q != wr_commit_q) && ((occ - {1'b0, pop}) < 2'd2);
    assign rd_ptr_d = rd_ptr_q + PW'(rd_en);

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!out_vld_q || pop) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = ram_vld_q;
                if (ram_vld_q) begin
                    skid_d = ram_rdata;
                end
            end else begin
                out_vld_d = ram_vld_q;
                if (ram_vld_q) begin
                    out_d = ram_rdata;
                end
            end
        end else if (ram_vld_q) begin
            skid_d     = ram_rdata;
            skid_vld_d = 1'b1;
        end
        // Framing flags never linger on an idle source.
        if (!out_vld_d) begin
            out_d[SWM_ENTRY_W-1 -: 2] = 2'b00;
        end
    end

    always_ff @(posedge clk_in_clk or negedge reset_in_rst_n) begin
        if (!reset_in_rst_n) begin
            state_q     <= WR_IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            orphan_q    <= 1'b0;
            drop_q      <= 1'b0;
            ready_q     <= 1'b0;
            ram_vld_q   <= 1'b0;
            out_q       <= '0;
            out_vld_q   <= 1'b0;
            skid_q      <= '0;
            skid_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            orphan_q    <= orphan_d;
            drop_q      <= drop_d;
            ready_q     <= 1'b1;
            ram_vld_q   <= rd_en;
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
            skid_q      <= skid_d;
            skid_vld_q  <= skid_vld_d;
        end
    end

    assign avalonst_sink_ready           = ready_q;
    assign avalonst_source_valid         = out_vld_q;
    assign avalonst_source_startofpacket = out_q[SWM_ENTRY_W-1];
    assign avalonst_source_endofpacket   = out_q[SWM_ENTRY_W-2];
    assign avalonst_source_data          = out_q[31:0];
    assign pkt_dropped                   = drop_q;

`ifdef SWM_RX_PKT_BUFFER_STATS_EN
    logic [15:0] drop_cnt_q, pkt_cnt_q;

    always_ff @(posedge clk_in_clk or negedge reset_in_rst_n) begin
        if (!reset_in_rst_n) begin
            drop_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            if (drop_d && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (commit) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end

    assign drop_count = drop_cnt_q;
    assign pkt_count  = pkt_cnt_q;
`endif

endmodule
